// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, fetches one word at a time over req/ack and
// hands it to decode over valid/ready. Redirects squash wrong-path fetches.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] pcNext;
  logic [31:0] drainAddr;

  assign target    = {redirect_pc[31:2], 2'b00};
  assign pcNext    = pc + 32'd4;
  // In DRAIN a same-cycle redirect must win over the previously latched target.
  assign drainAddr = redirect ? target : pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instruction <= 32'h0;
      pc_out      <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          imem_req    <= 1'b1;
          instr_valid <= 1'b0;
          state       <= FETCH;
          if (redirect) begin
            pc        <= target;
            imem_addr <= target;
          end else begin
            imem_addr <= pc;
          end
        end
        FETCH: begin
          if (redirect) begin
            pc          <= target;
            instr_valid <= 1'b0;
            if (imem_ack) begin
              imem_addr <= target;
              state     <= FETCH;
            end else begin
              // Request already on the bus cannot be withdrawn; wait it out.
              state <= DRAIN;
            end
          end else if (imem_ack) begin
            instruction <= imem_rdata;
            pc_out      <= imem_addr;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc          <= target;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= target;
            state       <= FETCH;
          end else if (instr_valid && instr_ready) begin
            pc          <= pcNext;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            imem_addr   <= pcNext;
            state       <= FETCH;
          end
        end
        DRAIN: begin
          instr_valid <= 1'b0;
          if (redirect) pc <= target;
          if (imem_ack) begin
            imem_addr <= drainAddr;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: memory and decoder are driven by hand
// from one sequence, outputs checked #1 after each rising edge.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int vectors = 0;
  int errs    = 0;

  instruction_fetch #(.RESET_PC(32'h00000000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc_out(pc_out), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus-side snapshot: request, address, valid.
  task automatic chkBus(input string tag, input logic req, input logic [31:0] addr,
                        input logic vld);
    chk({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    chk({tag, ".addr"},  imem_addr,            addr);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, vld});
  endtask

  // Decoder-side snapshot of a held word.
  task automatic chkWord(input string tag, input logic [31:0] word, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, ".instr"}, instruction,          word);
    chk({tag, ".pc"},    pc_out,               pc);
    chk({tag, ".req"},   {31'd0, imem_req},    32'd0);
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset state
    tick();
    chkBus("rst", 1'b0, 32'h0, 1'b0);
    chk("rst.instr", instruction, 32'h0);
    chk("rst.pc",    pc_out,      32'h0);
    reset = 1'b0;
    tick();                                   // IDLE -> FETCH
    chkBus("first_req", 1'b1, 32'h0, 1'b0);

    // Zero-wait memory, ready high: one word every two cycles
    imem_ack = 1'b1; imem_rdata = 32'h03E0FAA0; instr_ready = 1'b1;
    tick();
    chkWord("w0", 32'h03E0FAA0, 32'h0);
    tick();
    chkBus("fetch4", 1'b1, 32'h4, 1'b0);
    imem_rdata = 32'h11111111; instr_ready = 1'b0;
    tick();
    chkWord("w4", 32'h11111111, 32'h4);
    imem_ack = 1'b0;

    // Decoder stalls 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chkWord("stall", 32'h11111111, 32'h4);
    end
    instr_ready = 1'b1;
    tick();
    chkBus("fetch8", 1'b1, 32'h8, 1'b0);

    // Redirect while fetch of 8 is unacked -> DRAIN
    redirect = 1'b1; redirect_pc = 32'h00000103;
    tick();
    chkBus("drain0", 1'b1, 32'h8, 1'b0);
    redirect = 1'b0;
    tick();
    chkBus("drain1", 1'b1, 32'h8, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    chkBus("post_drain", 1'b1, 32'h100, 1'b0);
    imem_rdata = 32'h33333333;
    tick();
    chkWord("w100", 32'h33333333, 32'h100);

    // Memory ack delayed 3 cycles
    imem_ack = 1'b0;
    tick();
    chkBus("slow0", 1'b1, 32'h104, 1'b0);
    tick();
    chkBus("slow1", 1'b1, 32'h104, 1'b0);
    tick();
    chkBus("slow2", 1'b1, 32'h104, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h44444444; instr_ready = 1'b0;
    tick();
    chkWord("w104", 32'h44444444, 32'h104);
    imem_ack = 1'b0;

    // Redirect in HOLD with ready=1: held word dropped
    redirect = 1'b1; redirect_pc = 32'h00000040; instr_ready = 1'b1;
    tick();
    chkBus("hold_redir", 1'b1, 32'h40, 1'b0);
    redirect = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h55555555;
    tick();
    chkWord("w40", 32'h55555555, 32'h40);
    imem_ack = 1'b0;
    tick();
    chkBus("after40", 1'b1, 32'h44, 1'b0);

    // Redirect in FETCH coinciding with ack: data discarded, low bits masked
    redirect = 1'b1; redirect_pc = 32'hFFFFFFFF; imem_ack = 1'b1; imem_rdata = 32'hBADBAD00;
    tick();
    chkBus("fetch_redir_ack", 1'b1, 32'hFFFFFFFC, 1'b0);
    redirect = 1'b0; imem_rdata = 32'h66666666;
    tick();
    chkWord("wTop", 32'h66666666, 32'hFFFFFFFC);
    imem_ack = 1'b0;
    tick();
    chkBus("wrap", 1'b1, 32'h0, 1'b0);

    // Two redirects across DRAIN: latest target wins on the ack edge
    redirect = 1'b1; redirect_pc = 32'h00000200;
    tick();
    chkBus("drainA", 1'b1, 32'h0, 1'b0);
    redirect_pc = 32'h00000300; imem_ack = 1'b1; imem_rdata = 32'hBAD00BAD;
    tick();
    chkBus("drainB", 1'b1, 32'h300, 1'b0);

    // Reset while in DRAIN
    redirect_pc = 32'h00000500; imem_ack = 1'b0;
    tick();
    chkBus("drainC", 1'b1, 32'h300, 1'b0);
    redirect = 1'b0; reset = 1'b1;
    tick();
    chkBus("rst_drain", 1'b0, 32'h0, 1'b0);
    chk("rst_drain.instr", instruction, 32'h0);
    chk("rst_drain.pc",    pc_out,      32'h0);
    reset = 1'b0;
    tick();
    chkBus("restart", 1'b1, 32'h0, 1'b0);
    imem_ack = 1'b1; imem_rdata = 32'h77777777;
    tick();
    chkWord("wRestart", 32'h77777777, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Supplies the 32-bit instruction word that the decode/ALU datapath consumes.
- Owns the program counter (PC) and fetches from instruction memory over a req/ack handshake that may take several cycles.
- Presents each fetched word to the decoder over a valid/ready handshake.
- Accepts branch/jump redirects from execute and squashes any wrong-path fetch, including a fetch still outstanding at memory.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 00.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory; registered.
- imem_addr  output  32  fetch byte address; registered; bits [1:0] always 00.
- imem_ack  input  1  memory completes the transfer at the edge where it is sampled high while imem_req=1.
- imem_rdata  input  32  instruction word; valid only when imem_ack=1.
- instruction  output  32  held instruction word to the decoder (opcode [31:26], func [5:0], etc.).
- pc_out  output  32  address of the word currently on instruction.
- instr_valid  output  1  instruction/pc_out hold a valid word.
- instr_ready  input  1  decoder accepts the word.
- redirect  input  1  branch/jump taken; fetch continues at redirect_pc.
- redirect_pc  input  32  redirect target; bits [1:0] ignored (treated as 00).

Behaviour:
- Reset values, forced at any edge with reset=1 regardless of state:
  - state=IDLE, pc=RESET_PC.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instruction=0, pc_out=0.
- States: IDLE, FETCH, HOLD, DRAIN.
- IDLE: lasts exactly one cycle, then goes to FETCH with imem_req<=1 and imem_addr<=pc.
  - First imem_req=1 therefore appears in the second cycle after reset deasserts.
- FETCH: imem_req and imem_addr stay stable until an ack edge.
  - On an ack edge: instruction<=imem_rdata, pc_out<=imem_addr, instr_valid<=1, imem_req<=0, go to HOLD.
  - Zero-wait ack (ack in the first req cycle) is legal.
- HOLD: instruction, pc_out and instr_valid are held stable while instr_ready=0.
  - On an edge with instr_valid=1 and instr_ready=1 (and no redirect): pc<=pc+4, instr_valid<=0, imem_req<=1, imem_addr<=pc+4, go to FETCH.
- Throughput: one instruction per 2 cycles minimum with zero-wait memory and instr_ready held high. There is no prefetch overlap.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000.
- Redirect has priority over every other event except reset. At an edge with redirect=1:
  - pc<=redirect_pc with bits [1:0] forced to 00; instr_valid<=0.
  - A word held in HOLD is discarded even if instr_ready=1 in that cycle. The decoder must not count that handshake as accepted.
  - From HOLD or IDLE: go to FETCH, imem_req<=1, imem_addr<=new pc.
  - From FETCH with imem_ack=1 in that same cycle: discard imem_rdata, go to FETCH, imem_addr<=new pc, imem_req stays 1.
  - From FETCH with imem_ack=0: go to DRAIN. imem_req and imem_addr keep the old address, which the memory protocol forbids withdrawing.
- DRAIN: wait for ack; on the ack edge discard imem_rdata, set imem_addr<=pc, keep imem_req=1, go to FETCH.
  - A further redirect while in DRAIN only updates pc; the latest target wins. On the ack edge in the same cycle, imem_addr<=the new target.
- instr_valid is never 1 in FETCH, DRAIN or IDLE.
- No word from a squashed fetch ever reaches instruction.
- Reset mid-transfer: the outstanding memory request is abandoned. The memory must tolerate imem_req dropping without an ack on reset.

Test Plan:
- Reset release, memory ack'ing zero-wait returning 32'h03E0FAA0, instr_ready=1 -> imem_req first high 2 cycles after reset; imem_addr=0; instruction=32'h03E0FAA0 with pc_out=0; next imem_addr=4; one word every 2 cycles.
- Memory ack delayed 3 cycles -> imem_req/imem_addr stable for all 3 cycles; instr_valid rises the edge after ack.
- instr_ready held low 5 cycles in HOLD -> instruction/pc_out unchanged and instr_valid=1 throughout; no new request issued.
- redirect=1 with redirect_pc=32'h00000103 while FETCH at addr 8 is unacked -> enter DRAIN, keep addr 8 until ack, discard 8's data, then fetch 32'h00000100; pc_out of the next valid word is 0x100.
- redirect with instr_ready=1 in HOLD, target 0x40 -> held word dropped; next valid word has pc_out=0x40; pc does not advance to the old pc+4.
- pc=32'hFFFFFFFC accepted -> next imem_addr=0. Separately, reset asserted in DRAIN -> imem_req=0, instr_valid=0 and pc=RESET_PC the next cycle.
